// File: rtl/sequence_lut_reader.sv
// sequence_lut_reader: follows the upstream step index, fetches one CHANNELS-wide
// value set per step from an external BRAM and commits it atomically to values.
// Tracks position within the period, completed periods, completion and underrun.
// Optional build macro SEQ_HOLD_LAST_EN: when defined, values keep the last
// committed entry after the sequence completes; otherwise they clear to zero.
module sequence_lut_reader #(
    parameter int CHANNELS     = 4,
    parameter int DATA_W       = 16,
    parameter int ADDR_W       = 14,
    parameter int BRAM_LATENCY = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [31:0]                step_counter,
    input  logic                       start,
    input  logic [31:0]                seq_length,
    input  logic [31:0]                num_periods,
    output logic [ADDR_W-1:0]          bram_addr,
    output logic                       bram_en,
    input  logic [DATA_W-1:0]          bram_rdata,
    output logic [CHANNELS*DATA_W-1:0] values,
    output logic                       values_valid,
    output logic [31:0]                seq_index,
    output logic [31:0]                period_count,
    output logic                       seq_active,
    output logic                       seq_done,
    output logic                       underrun
);
    localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic [CH_W-1:0] CH_LAST = CH_W'(CHANNELS - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_WAIT   = 3'd2;
    localparam logic [2:0] S_COMMIT = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    logic [2:0]  state;
    logic        start_d;
    logic [31:0] prev_step;
    logic [31:0] len_q;
    logic [31:0] nper_q;
    logic [31:0] fetch_idx;   // entry being fetched; frozen so a mid-fetch step cannot mix entries
    logic [CH_W-1:0] ch;
    logic        pending;     // one queued refetch of the latest index after an underrun

    logic [CHANNELS-1:0][DATA_W-1:0] shadow;
    logic [CHANNELS-1:0][DATA_W-1:0] vals_q;

    // read-return tracking: vld_pipe[k] marks a read issued k clocks ago
    logic [BRAM_LATENCY:1] vld_pipe;
    logic [CH_W-1:0]       ch_pipe [1:BRAM_LATENCY];

    logic [31:0] eff_len, nxt_idx, nxt_per;
    logic start_rise, abort, adv, wrap, finish, capture, last_cap, in_flight, flush;

    // next-position arithmetic and event decode
    always_comb begin
        eff_len    = (len_q == 32'd0) ? 32'd1 : len_q;
        wrap       = (seq_index == eff_len - 32'd1);
        nxt_idx    = wrap ? 32'd0 : seq_index + 32'd1;
        nxt_per    = wrap ? period_count + 32'd1 : period_count;
        finish     = (nper_q != 32'd0) && (nxt_per == nper_q);
        start_rise = start & ~start_d;
        abort      = seq_active & ~start;
        adv        = seq_active & start & (step_counter != prev_step);
        capture    = vld_pipe[BRAM_LATENCY] & ((state == S_FETCH) || (state == S_WAIT));
        last_cap   = capture & (ch_pipe[BRAM_LATENCY] == CH_LAST);
        in_flight  = (state == S_FETCH) || (state == S_WAIT) || (state == S_COMMIT);
        flush      = abort | (adv & finish);
    end

    assign bram_en   = (state == S_FETCH);
    assign bram_addr = bram_en ? ADDR_W'(fetch_idx * 32'(CHANNELS) + 32'(ch)) : '0;
    assign values    = vals_q;

    // shift read strobes so returning words land in the right shadow slot
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            vld_pipe <= '0;
        end else begin
            vld_pipe[1] <= bram_en;
            for (int i = 2; i <= BRAM_LATENCY; i++) vld_pipe[i] <= vld_pipe[i-1];
        end
        ch_pipe[1] <= ch;
        for (int i = 2; i <= BRAM_LATENCY; i++) ch_pipe[i] <= ch_pipe[i-1];
    end

    // sequencing FSM, counters, shadow capture and commit
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            start_d      <= start;
            prev_step    <= step_counter;
            len_q        <= '0;
            nper_q       <= '0;
            fetch_idx    <= '0;
            ch           <= '0;
            pending      <= 1'b0;
            shadow       <= '0;
            vals_q       <= '0;
            values_valid <= 1'b0;
            seq_index    <= '0;
            period_count <= '0;
            seq_active   <= 1'b0;
            seq_done     <= 1'b0;
            underrun     <= 1'b0;
        end else begin
            start_d      <= start;
            prev_step    <= step_counter;
            values_valid <= 1'b0;
            if (capture) shadow[ch_pipe[BRAM_LATENCY]] <= bram_rdata;

            if (start_rise && !seq_active) begin
                len_q        <= seq_length;
                nper_q       <= num_periods;
                seq_index    <= '0;
                period_count <= '0;
                seq_done     <= 1'b0;
                underrun     <= 1'b0;
                pending      <= 1'b0;
                seq_active   <= 1'b1;
                fetch_idx    <= '0;
                ch           <= '0;
                state        <= S_FETCH;
            end else if (abort) begin
                state      <= S_IDLE;
                seq_active <= 1'b0;
                vals_q     <= '0;
                pending    <= 1'b0;
            end else if (seq_active) begin
                case (state)
                    S_FETCH: begin
                        ch <= ch + 1'b1;
                        if (ch == CH_LAST) state <= S_WAIT;
                    end
                    S_WAIT: if (last_cap) state <= S_COMMIT;
                    S_COMMIT: begin
                        vals_q       <= shadow;
                        values_valid <= 1'b1;
                        if (pending) begin
                            state     <= S_FETCH;
                            fetch_idx <= seq_index;
                            ch        <= '0;
                            pending   <= 1'b0;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                    default: ;
                endcase

                if (adv) begin
                    seq_index    <= nxt_idx;
                    period_count <= nxt_per;
                    if (finish) begin
                        state        <= S_DONE;
                        seq_active   <= 1'b0;
                        seq_done     <= 1'b1;
                        values_valid <= 1'b0;
                        pending      <= 1'b0;
`ifdef SEQ_HOLD_LAST_EN
                        vals_q       <= vals_q;
`else
                        vals_q       <= '0;
`endif
                    end else if (!in_flight) begin
                        state     <= S_FETCH;
                        fetch_idx <= nxt_idx;
                        ch        <= '0;
                    end else begin
                        underrun <= 1'b1;
                        if (state == S_COMMIT) begin
                            state     <= S_FETCH;
                            fetch_idx <= nxt_idx;
                            ch        <= '0;
                            pending   <= 1'b0;
                        end else begin
                            pending <= 1'b1;
                        end
                    end
                end
            end
        end
    end
endmodule
